ndro_bank_sequencer: RTL

- Sequences a bank of basic NDRO cells (set/reset/clk pulse inputs, out level) on behalf of several requesters.
- Arbitrates requests round-robin and issues exactly one single-cycle set, reset or clk pulse per transaction.
- Enforces a guard interval between pulses, samples cell output for reads and returns one response per transaction.
- Sits between control logic and the NDRO array in the integration benches.

---
 rtl/ndro_seq_pkg.sv | 23 ++
 rtl/ndro_rr_arbiter.sv | 33 +++
 rtl/ndro_bank_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ndro_seq_pkg.sv
// Shared types for the NDRO bank sequencer: op codes, FSM states
// and a width helper giving at least one bit for any count.
package ndro_seq_pkg;

    typedef enum logic [1:0] {
        OP_SET   = 2'd0,
        OP_RESET = 2'd1,
        OP_READ  = 2'd2,
        OP_NOP   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GUARD = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ndro_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 upward with wrap.
// Ports: req (requests), ptr (last winner), en (grant enable) -> gnt (one-hot), idx.
module ndro_rr_arbiter
    import ndro_seq_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int ID_W = clog2w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx
);

    always_comb begin
        logic found;
        int   j;
        found = 1'b0;
        j     = 0;
        gnt   = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = en;
                idx    = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/ndro_bank_sequencer.sv
// Sequences single-cycle set/reset/clk pulses into a bank of NDRO cells for
// several round-robin arbitrated requesters, with a guard gap and one response
// per transaction.
// Ports: clk, rst_n, req_valid/req_ready/req_op/req_addr (requests),
// rsp_valid/rsp_id/rsp_data (response), cell_set/cell_reset/cell_clk/cell_out
// (array side), busy, err.
// Optional: define NDRO_SHADOW_CHECK_EN to keep a shadow of written cell
// values and flag read mismatches on the sticky err output.
module ndro_bank_sequencer
    import ndro_seq_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int NUM_CELLS = 4,
    parameter int GUARD_CYC = 2,
    parameter int READ_LAT  = 1,
    localparam int ADDR_W = clog2w(NUM_CELLS),
    localparam int ID_W   = clog2w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_data,
    output logic [NUM_CELLS-1:0]      cell_set,
    output logic [NUM_CELLS-1:0]      cell_reset,
    output logic [NUM_CELLS-1:0]      cell_clk,
    input  logic [NUM_CELLS-1:0]      cell_out,
    output logic                      busy,
    output logic                      err
);

    localparam int CNT_W = clog2w(GUARD_CYC);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, id_q, win_idx;
    logic [NUM_REQ-1:0]  gnt;
    op_e                 op_q, sel_op;
    logic [ADDR_W-1:0]   addr_q, sel_addr;
    logic [CNT_W-1:0]    cnt_q;
    logic                rd_q, smp, cap, accept, last_g;
    logic                in_guard;

    // Out-of-range addresses decode to all zeros, suppressing the pulse.
    function automatic logic [NUM_CELLS-1:0] dec(input logic [ADDR_W-1:0] a);
        logic [NUM_CELLS-1:0] h;
        h = '0;
        for (int c = 0; c < NUM_CELLS; c++) h[c] = (int'(a) == c);
        return h;
    endfunction

    ndro_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .en  (state_q == ST_IDLE),
        .gnt (gnt),
        .idx (win_idx)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;
    assign busy      = (state_q != ST_IDLE);
    assign in_guard  = (state_q == ST_GUARD);
    assign last_g    = (cnt_q == CNT_W'(GUARD_CYC - 1));
    assign cap       = in_guard && (op_q == OP_READ) &&
                       (cnt_q == CNT_W'(READ_LAT - 1));
    assign smp       = |(cell_out & dec(addr_q));

    always_comb begin
        sel_op   = OP_NOP;
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_op   = op_e'(req_op[2*i +: 2]);
                sel_addr = req_addr[ADDR_W*i +: ADDR_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_GUARD;
            ST_GUARD: if (last_g) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Pulses are registered on the grant edge so they appear in ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= ID_W'(NUM_REQ - 1);
            id_q       <= '0;
            op_q       <= OP_NOP;
            addr_q     <= '0;
            cnt_q      <= '0;
            rd_q       <= 1'b0;
            cell_set   <= '0;
            cell_reset <= '0;
            cell_clk   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cell_set   <= '0;
            cell_reset <= '0;
            cell_clk   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= 1'b0;
            if (accept) begin
                ptr_q  <= win_idx;
                id_q   <= win_idx;
                op_q   <= sel_op;
                addr_q <= sel_addr;
                rd_q   <= 1'b0;
                case (sel_op)
                    OP_SET:   cell_set   <= dec(sel_addr);
                    OP_RESET: cell_reset <= dec(sel_addr);
                    OP_READ:  cell_clk   <= dec(sel_addr);
                    default:  ;
                endcase
            end
            cnt_q <= (in_guard && !last_g) ? cnt_q + 1'b1 : '0;
            if (cap) rd_q <= smp;
            if (in_guard && last_g) begin
                rsp_valid <= 1'b1;
                rsp_id    <= id_q;
                // Capture may coincide with the last guard cycle.
                rsp_data  <= cap ? smp : rd_q;
            end
        end
    end

`ifdef NDRO_SHADOW_CHECK_EN
    logic [NUM_CELLS-1:0] shadow_q;
    logic                 err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_q == ST_ISSUE) begin
                if (op_q == OP_SET)
                    shadow_q <= shadow_q | dec(addr_q);
                else if (op_q == OP_RESET)
                    shadow_q <= shadow_q & ~dec(addr_q);
            end
            if (cap && (|dec(addr_q)) &&
                (smp != |(shadow_q & dec(addr_q))))
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
